// File: rtl/i2s_tx.sv
// I2S stereo transmitter: divides sample_clock into SCK and frames WS/SD with the one-SCK delay.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_count output.
module i2s_tx #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned CLK_DIV      = 4
) (
  input  logic                    sample_clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  output logic                    in_ready,
  output logic                    sck,
  output logic                    ws,
  output logic                    sd,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_count
`endif
);

  localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
  localparam int unsigned BW        = $clog2(FrameBits);
  localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LastBit = BW'(FrameBits - 1);

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic                    sck_q, sck_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    ws_q, ws_d;
  logic                    sd_q, sd_d;
  logic                    ur_q, ur_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] shad_l_q, shad_l_d, shad_r_q, shad_r_d;
  logic [SAMPLE_WIDTH-1:0] l_sh, r_sh;
  logic                    tick, fall, frame_load, accept;

  assign tick       = (div_cnt_q == DW'(CLK_DIV - 1));
  assign fall       = tick & sck_q;
  assign frame_load = fall & (bit_q == LastBit);
  assign accept     = in_valid & ~hold_full_q;

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    sck_d       = tick ? ~sck_q : sck_q;
    bit_d       = bit_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    ur_d        = frame_load & ~hold_full_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shad_l_d    = shad_l_q;
    shad_r_d    = shad_r_q;
    l_sh        = '0;
    r_sh        = '0;

    if (frame_load) begin
      shad_l_d    = hold_full_q ? hold_l_q : '0;
      shad_r_d    = hold_full_q ? hold_r_q : '0;
      hold_full_d = 1'b0;
    end
    // accept is only possible when holding is empty, so it always lands after the load
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = in_left;
      hold_r_d    = in_right;
    end

    if (fall) begin
      bit_d = (bit_q == LastBit) ? '0 : bit_q + BW'(1);
      ws_d  = (bit_d >= BW'(SLOT_WIDTH));
      l_sh  = shad_l_d << (bit_d - BW'(1));
      r_sh  = shad_r_d << (bit_d - BW'(SLOT_WIDTH + 1));
      if (bit_d >= BW'(1) && bit_d <= BW'(SAMPLE_WIDTH)) begin
        sd_d = l_sh[SAMPLE_WIDTH-1];
      end else if (bit_d >= BW'(SLOT_WIDTH + 1) && bit_d <= BW'(SLOT_WIDTH + SAMPLE_WIDTH)) begin
        sd_d = r_sh[SAMPLE_WIDTH-1];
      end else begin
        sd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      sck_q       <= 1'b0;
      bit_q       <= LastBit;
      ws_q        <= 1'b1;
      sd_q        <= 1'b0;
      ur_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shad_l_q    <= '0;
      shad_r_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sck_q       <= sck_d;
      bit_q       <= bit_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      ur_q        <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shad_l_q    <= shad_l_d;
      shad_r_q    <= shad_r_d;
    end
  end

  assign in_ready = ~hold_full_q;
  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = ur_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_q;

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      underrun_count_q <= '0;
    end else if (ur_d && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_q <= underrun_count_q + 16'd1;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (SAMPLE_WIDTH=24, SLOT_WIDTH=32, CLK_DIV=2): frame table plus
// hand-written sequences for backpressure, load-cycle offers and mid-frame reset.
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_left, in_right;
  logic        in_ready, sck, ws, sd, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  i2s_tx #(
    .SAMPLE_WIDTH(24),
    .SLOT_WIDTH  (32),
    .CLK_DIV     (2)
  ) dut (
    .sample_clock(clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_ready    (in_ready),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count(ucnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Monitor state, owned by the negedge process below.
  logic [5:0]  mon_b;
  logic        sck_prev;
  logic [63:0] cur_sd, cur_ws, last_sd, last_ws;
  int          load_cnt = 0;
  logic        ur_at_load;
  int          stray_ur = 0;
  int          spacing_err = 0;
  int          gap;
  logic        had_fall;
  logic        acc_pend;
  logic [47:0] pend_pair;
  int          acc_in_frame, last_acc;
  logic [47:0] acc_q[$];

  initial begin
    mon_b = 6'd63; sck_prev = 1'b0; cur_sd = '0; cur_ws = '0; last_sd = '0; last_ws = '0;
    ur_at_load = 1'b0; gap = 0; had_fall = 1'b0; acc_pend = 1'b0; pend_pair = '0;
    acc_in_frame = 0; last_acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_b = 6'd63; sck_prev = 1'b0; had_fall = 1'b0; gap = 0;
        acc_pend = 1'b0; acc_in_frame = 0;
      end else begin
        gap++;
        if (sck_prev && !sck) begin
          if (had_fall && gap != 4) spacing_err++;
          gap = 0;
          had_fall = 1'b1;
          mon_b = mon_b + 6'd1;
          if (mon_b == 6'd0) begin
            last_sd = cur_sd; last_ws = cur_ws;
            last_acc = acc_in_frame; acc_in_frame = 0;
            ur_at_load = underrun;
            load_cnt++;
          end else if (underrun) begin
            stray_ur++;
          end
          cur_sd[mon_b] = sd;
          cur_ws[mon_b] = ws;
        end else if (underrun) begin
          stray_ur++;
        end
        // an accept on the load edge belongs to the frame that load starts
        if (acc_pend) begin
          acc_in_frame++;
          acc_q.push_back(pend_pair);
        end
        acc_pend  = in_valid && in_ready;
        pend_pair = {in_left, in_right};
        sck_prev  = sck;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    v = '0;
    for (int k = 1; k <= 24; k++) begin
      v[k]      = l[24-k];
      v[32 + k] = r[24-k];
    end
    return v;
  endfunction

  localparam logic [63:0] ExpWs = {32'hFFFF_FFFF, 32'h0000_0000};

  task automatic wait_loads(input int target);
    int n;
    n = 0;
    while (load_cnt < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_timeout", 64'(load_cnt >= target), 64'd1);
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("offer_ready", in_ready, 1);
    in_valid = 1'b1; in_left = l; in_right = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ready_drop", in_ready, 0);
  endtask

  typedef struct {
    bit          offer;
    logic [23:0] l, r;
    bit          exp_ur;
    logic [23:0] exp_l, exp_r;
  } vec_t;

  vec_t        vec[6];
  int          lc, seen, cyc, first;
  logic        prev;
  logic [47:0] p;
  int          bp_base;

  initial begin
    vec[0] = '{1'b1, 24'hA5A5A5, 24'h3C3C3C, 1'b0, 24'hA5A5A5, 24'h3C3C3C};
    vec[1] = '{1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000};
    vec[2] = '{1'b1, 24'h800001, 24'h7FFFFE, 1'b0, 24'h800001, 24'h7FFFFE};
    vec[3] = '{1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 24'hFFFFFF, 24'h000001};
    vec[4] = '{1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000};
    vec[5] = '{1'b1, 24'h123456, 24'hABCDEF, 1'b0, 24'h123456, 24'hABCDEF};

    rst_n = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 1);
    chk("rst_sd", sd, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("rst_ucnt", ucnt, 0);
`endif
    rst_n = 1'b1;

    // Frame table: entry i is offered before load i and must appear in frame i.
    lc = load_cnt;
    if (vec[0].offer) offer(vec[0].l, vec[0].r);
    for (int i = 0; i <= 6; i++) begin
      wait_loads(lc + i + 1);
      if (i > 0) begin
        chk($sformatf("frame%0d_sd", i - 1), last_sd, exp_sd(vec[i-1].exp_l, vec[i-1].exp_r));
        chk($sformatf("frame%0d_ws", i - 1), last_ws, ExpWs);
      end
      if (i < 6) chk($sformatf("load%0d_underrun", i), ur_at_load, vec[i].exp_ur);
      if (i < 5 && vec[i+1].offer) offer(vec[i+1].l, vec[i+1].r);
    end

    // Backpressure: in_valid held high with data changing every cycle.
    bp_base = acc_q.size();
    lc = load_cnt;
    seen = 0; cyc = 0;
    in_valid = 1'b1;
    while (seen < 3 && cyc < 1200) begin
      in_left  = 24'h400000 + 24'(cyc);
      in_right = 24'hC00000 - 24'(cyc);
      @(posedge clk); #1;
      cyc++;
      if (load_cnt != lc + seen) begin
        seen++;
        chk("bp_acc_per_frame", 64'(last_acc), 64'd1);
        chk("bp_underrun", ur_at_load, 0);
        if (seen >= 2) begin
          p = acc_q[bp_base + seen - 2];
          chk("bp_frame_sd", last_sd, exp_sd(p[47:24], p[23:0]));
        end
      end
    end
    in_valid = 1'b0;
    chk("bp_timeout", 64'(seen), 64'd3);

    // Pair accepted after the last backpressure load drains next; then offer on the load edge.
    lc = load_cnt;
    wait_loads(lc + 1);
    chk("drain_underrun", ur_at_load, 0);
    repeat (254) @(posedge clk);
    #1;
    in_valid = 1'b1; in_left = 24'h5A0F33; in_right = 24'hC3E1F7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("simul_held", in_ready, 0);
    wait_loads(lc + 2);
    chk("simul_underrun", ur_at_load, 1);
    p = acc_q[bp_base + 3];
    chk("drain_frame_sd", last_sd, exp_sd(p[47:24], p[23:0]));
    wait_loads(lc + 3);
    chk("simul_zero_frame", last_sd, 64'd0);
    chk("simul_next_ur", ur_at_load, 0);
    wait_loads(lc + 4);
    chk("simul_frame_sd", last_sd, exp_sd(24'h5A0F33, 24'hC3E1F7));

    // Mid-frame reset with a pair pending in holding.
    offer(24'h777777, 24'h111111);
    repeat (70) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_ws", ws, 1);
    chk("mid_rst_sd", sd, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_underrun", underrun, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lc = load_cnt;
    prev = sck; first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (prev && !sck && first == 0) first = n;
      prev = sck;
    end
    chk("first_fall_cycles", 64'(first), 64'd4);
    wait_loads(lc + 1);
    chk("rst_discard_ur", ur_at_load, 1);
    wait_loads(lc + 2);
    chk("ur2", ur_at_load, 1);
    chk("ur_frame1_zero", last_sd, 64'd0);
    wait_loads(lc + 3);
    chk("ur3", ur_at_load, 1);
    chk("ur_frame2_zero", last_sd, 64'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ucnt_three", ucnt, 3);
    force dut.underrun_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.underrun_count_q;
    wait_loads(lc + 4);
    chk("ucnt_reach_max", ucnt, 16'hFFFF);
    wait_loads(lc + 5);
    chk("ucnt_saturate", ucnt, 16'hFFFF);
`endif

    chk("stray_underrun", 64'(stray_ur), 64'd0);
    chk("sck_spacing", 64'(spacing_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
